hazard_sequencer: RTL and testbench

//   Pipeline sequencer for the 5-stage core. Drives enable/flush of PC, IF/ID, ID/EX, EX/MEM and
//   MEM/WB latches from hit, hazard and branch status. idex_en/idex_flush drive idW/idRST of id_ex_if.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/sat_counter.sv | 21 ++
 rtl/hazard_sequencer.sv | 112 +++++++++++
 tb/tb_hazard_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the pipeline hazard sequencer
package cpu_types_pkg;

    typedef enum logic [1:0] {HZ_RUN, HZ_MEMWAIT, HZ_HALT} hzd_state_t;

    typedef logic [4:0] regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // A load in EX feeds an operand read in ID; $zero never creates a dependency.
    function automatic logic load_use_hit(
        input logic     ex_load,
        input regbits_t ex_rt,
        input regbits_t id_rs,
        input regbits_t id_rt,
        input logic     id_uses_rt
    );
        return ex_load && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = 1;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - enable/flush sequencing for the 5-stage pipeline latches
module hazard_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             ex_load,
    input  regbits_t         ex_rt,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_brtaken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    hzd_state_t state, state_nxt;
    logic       evaluate;
    logic       load_use;

    assign load_use = load_use_hit(ex_load, ex_rt, id_rs, id_rt, id_uses_rt);

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        halted     = 1'b0;
        state_nxt  = state;
        // A completed data access in MEMWAIT resolves the normal rules in the same cycle.
        evaluate   = ((state == HZ_RUN) && !(mem_req && !dhit)) ||
                     ((state == HZ_MEMWAIT) && dhit);

        if (evaluate) begin
            state_nxt = HZ_RUN;
            if (mem_halt) begin
                state_nxt = HZ_HALT;
            end else if (ex_brtaken) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!ihit) begin
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end else begin
            case (state)
                HZ_RUN:     state_nxt = HZ_MEMWAIT;
                HZ_MEMWAIT: state_nxt = HZ_MEMWAIT;
                HZ_HALT: begin
                    state_nxt = HZ_HALT;
                    halted    = 1'b1;
                end
                default:    state_nxt = HZ_RUN;
            endcase
        end

        if (RST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            halted     = 1'b0;
            state_nxt  = HZ_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        state <= state_nxt;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (!RST && (state != HZ_HALT) && !pc_en),
        .q   (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed and random checks of hazard_sequencer against a rule model
module tb_hazard_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ihit, dhit, mem_req, ex_load, id_uses_rt, ex_brtaken, mem_halt;
    logic [4:0] ex_rt, id_rs, id_rt;

    logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_memwb_en, a_halted;
    logic [31:0] a_stall_cnt;
    logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_memwb_en, b_halted;
    logic [1:0]  b_stall_cnt;

    hazard_sequencer #(.CNT_W(32)) dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .ex_load(ex_load),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_brtaken(ex_brtaken), .mem_halt(mem_halt),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .idex_en(a_idex_en),
        .idex_flush(a_idex_flush), .exmem_en(a_exmem_en), .memwb_en(a_memwb_en),
        .halted(a_halted), .stall_cnt(a_stall_cnt)
    );

    hazard_sequencer #(.CNT_W(2)) dut_small (
        .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .ex_load(ex_load),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_brtaken(ex_brtaken), .mem_halt(mem_halt),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .idex_en(b_idex_en),
        .idex_flush(b_idex_flush), .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .halted(b_halted), .stall_cnt(b_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    bit     m_wait = 1'b0;
    bit     m_halt = 1'b0;
    longint m_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control vector bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
    task automatic cyc();
        logic [6:0] exp_v;
        bit         lu, memstall;
        longint     cap32;
        @(negedge clk);
        lu = ex_load && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        memstall = !dhit && (mem_req || m_wait);
        if (rst)                      exp_v = 7'b0010100;
        else if (m_halt || memstall)  exp_v = 7'b0000000;
        else if (mem_halt)            exp_v = 7'b0000000;
        else if (ex_brtaken)          exp_v = 7'b1010111;
        else if (lu)                  exp_v = 7'b0000111;
        else if (!ihit)               exp_v = 7'b0011011;
        else                          exp_v = 7'b1101011;
        cap32 = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
        check("ctl", {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_memwb_en}, exp_v);
        check("ctl_small", {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_memwb_en}, exp_v);
        check("halted", a_halted, !rst && m_halt);
        check("stall_cnt", a_stall_cnt, cap32);
        check("stall_cnt_small", b_stall_cnt, (m_cnt > 3) ? 3 : m_cnt);
        @(posedge clk);
        if (rst) begin
            m_wait = 1'b0;
            m_halt = 1'b0;
            m_cnt  = 0;
        end else if (!m_halt) begin
            if (!exp_v[6]) m_cnt++;
            if (memstall) begin
                m_wait = 1'b1;
            end else begin
                m_wait = 1'b0;
                if (mem_halt) m_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; ex_load = 1'b0; id_uses_rt = 1'b0;
        ex_brtaken = 1'b0; mem_halt = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    initial begin
        idle();
        rst = 1'b1; mem_req = 1'b1; dhit = 1'b0;
        cyc(); cyc();
        idle(); cyc();

        ex_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; cyc();
        ex_load = 1'b0; cyc();
        ex_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; cyc();
        idle(); id_uses_rt = 1'b1; ex_load = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; cyc();

        idle(); mem_req = 1'b1; dhit = 1'b0;
        repeat (3) cyc();
        dhit = 1'b1; cyc();
        idle(); cyc();

        ex_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_brtaken = 1'b1; cyc();
        idle(); ex_brtaken = 1'b1; ihit = 1'b0; cyc();
        idle(); ihit = 1'b0; cyc();

        idle(); mem_halt = 1'b1; cyc();
        mem_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ihit = i[0]; cyc();
        end
        rst = 1'b1; cyc();
        idle(); cyc();

        rst = 1'b1; cyc();
        idle(); ihit = 1'b0;
        repeat (5) cyc();
        idle(); cyc();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) < 3);
            ihit       = ($urandom_range(0, 99) < 75);
            dhit       = ($urandom_range(0, 99) < 50);
            mem_req    = ($urandom_range(0, 99) < 30);
            ex_load    = ($urandom_range(0, 99) < 40);
            id_uses_rt = $urandom_range(0, 1);
            ex_brtaken = ($urandom_range(0, 99) < 15);
            mem_halt   = ($urandom_range(0, 99) < 2);
            ex_rt      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
